// File: rtl/hazard_pipe_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS32 pipeline, built on a shadow scoreboard of post-ID stages.
// Stall/forward decisions are same-cycle combinational; ext_stall freezes everything. `HAZ_PERF_EN adds saturating perf counters.
module hazard_pipe_ctrl #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_branch,
  input  logic              id_pcsrc,
  input  logic              ext_stall,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        ex_fwd_rs,
  output logic [1:0]        ex_fwd_rt,
  output logic              id_fwd_rs,
  output logic              id_fwd_rt,
`ifdef HAZ_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  fwd_cnt,
`endif
  output logic              hazard_stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
  } sb_t;

  sb_t [DEPTH-1:0] r_sb;
  sb_t             w_id_entry;
  sb_t             w_e0, w_e1, w_e2;
  logic            w_m0_rs, w_m0_rt, w_m1_rs, w_m1_rt;
  logic            w_stall;
  logic [1:0]      w_ex_rs, w_ex_rt;
  logic            w_unused;

  function automatic logic f_match(input sb_t e, input logic [REG_AW-1:0] src, input logic uses);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == src) && uses;
  endfunction

  // Youngest producer wins; stages past WB have already written the regfile.
  function automatic logic [1:0] f_ex_sel(input sb_t c, input sb_t p1, input sb_t p2,
                                          input logic [REG_AW-1:0] src, input logic uses);
    if (!c.valid)                     return 2'd0;
    else if (f_match(p1, src, uses))  return 2'd1;
    else if (f_match(p2, src, uses))  return 2'd2;
    else                              return 2'd0;
  endfunction

  assign w_id_entry = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread,
                        rs: id_rs, rt: id_rt, uses_rs: id_uses_rs, uses_rt: id_uses_rt};

  assign w_e0 = r_sb[0];
  assign w_e1 = r_sb[1];
  assign w_e2 = r_sb[2];
  assign w_unused = ^r_sb;

  assign w_m0_rs = f_match(w_e0, id_rs, id_uses_rs);
  assign w_m0_rt = f_match(w_e0, id_rt, id_uses_rt);
  assign w_m1_rs = f_match(w_e1, id_rs, id_uses_rs);
  assign w_m1_rt = f_match(w_e1, id_rt, id_uses_rt);

  assign w_stall = id_valid & (
                     (w_e0.memread & (w_m0_rs | w_m0_rt)) |
                     (id_branch & (w_m0_rs | w_m0_rt)) |
                     (id_branch & w_e1.memread & (w_m1_rs | w_m1_rt)));

  assign w_ex_rs = f_ex_sel(w_e0, w_e1, w_e2, w_e0.rs, w_e0.uses_rs);
  assign w_ex_rt = f_ex_sel(w_e0, w_e1, w_e2, w_e0.rt, w_e0.uses_rt);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_sb <= '0;
    end else if (!ext_stall) begin
      r_sb[0] <= (id_valid && !w_stall) ? w_id_entry : sb_t'('0);
      for (int k = 1; k < DEPTH; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    ex_fwd_rs    = 2'd0;
    ex_fwd_rt    = 2'd0;
    id_fwd_rs    = 1'b0;
    id_fwd_rt    = 1'b0;
    hazard_stall = 1'b0;
    if (Reset) begin
      pc_en        = !(w_stall | ext_stall);
      if_id_en     = !(w_stall | ext_stall);
      // A stalled redirect is dropped here and re-resolved once the hazard clears.
      if_id_flush  = id_pcsrc & id_valid & !w_stall & !ext_stall;
      id_ex_bubble = w_stall & !ext_stall;
      ex_fwd_rs    = w_ex_rs;
      ex_fwd_rt    = w_ex_rt;
      id_fwd_rs    = w_m1_rs & !w_e1.memread;
      id_fwd_rt    = w_m1_rt & !w_e1.memread;
      hazard_stall = w_stall;
    end
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_fwd_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (id_ex_bubble && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (if_id_flush && (r_flush_cnt != '1))  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if (((ex_fwd_rs != 2'd0) || (ex_fwd_rt != 2'd0)) && !ext_stall && (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: doc/hazard_pipe_ctrl.md
Name: hazard_pipe_ctrl

Overview:
Hazard detection and forwarding controller for the 5-stage MIPS32 pipeline (IF, ID, EX, MEM, WB). It keeps a shadow scoreboard of in-flight instructions past ID, which gives it its sequential state. From that scoreboard it drives:
- PC and IF/ID enables
- IF/ID flush
- ID/EX bubble insertion
- EX-stage operand forwarding selects
- ID-stage branch-compare forwarding selects

It replaces the free-running pipeline, which has no interlocks. The tracked depth and register-address width are parametrised.

Parameters:
REG_AW, 5, register address width; register 0 is hardwired zero.
DEPTH, 3, number of tracked post-ID stages (index 0=EX, 1=MEM, 2=WB); legal range 3..6; stages above 2 model extra writeback latency.
CNT_W, 16, width of the perf counters (optional feature only).

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  ID source register rs
id_rt  in  REG_AW  ID source register rt
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_rd  in  REG_AW  ID destination (already muxed rt/rd/31)
id_regwrite  in  1  ID instruction writes a register
id_memread  in  1  ID instruction is a load
id_branch  in  1  ID instruction compares operands in ID (beq/bne/jr)
id_pcsrc  in  1  ID redirect taken
ext_stall  in  1  memory busy; freeze whole pipeline
pc_en  out  1  PC load enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  zero IF/ID on next edge
id_ex_bubble  out  1  load NOP controls into ID/EX
ex_fwd_rs  out  2  EX rs select: 0 regfile value, 1 MEM ALU result, 2 WB write data
ex_fwd_rt  out  2  EX rt select, same encoding
id_fwd_rs  out  1  ID branch rs select: 1 takes EX/MEM ALU result
id_fwd_rt  out  1  ID branch rt select, same encoding
hazard_stall  out  1  ID is held this cycle

Behaviour:
Scoreboard:
- Each entry holds {valid, rd, regwrite, memread, rs, rt, uses_rs, uses_rt}.
- Reset low clears all valid bits immediately, independent of Clk.
- On each edge with ext_stall=0:
  - entry[0] <= ID fields when id_valid=1 and hazard_stall=0; otherwise an entry with valid=0.
  - entry[k] <= entry[k-1] for k=1..DEPTH-1.
- With ext_stall=1, every entry holds its value.

A match is defined as: entry valid, regwrite=1, rd!=0, rd equals the source register, and the corresponding uses flag set.

Hazard stall (combinational, ID-qualified by id_valid). hazard_stall=1 when any of these holds:
- Load-use: entry[0] is memread and matches rs or rt.
- Branch on an EX result: id_branch=1 and entry[0] matches any used source.
- Branch on a load in MEM: id_branch=1 and entry[1] is memread and matches.

Enables and flush:
- pc_en = if_id_en = !(hazard_stall | ext_stall).
- id_ex_bubble = hazard_stall & !ext_stall.
- if_id_flush = id_pcsrc & id_valid & !hazard_stall & !ext_stall. Stall wins over redirect; the branch re-resolves the next cycle.

EX forwarding:
- entry[0].rs/rt is compared against entry[1], then entry[2]; the youngest match wins (1 before 2).
- No forwarding from index >=3; those writes have reached the regfile.
- The value is 0 when entry[0] is invalid or the source is r0.

ID forwarding:
- id_fwd_rs/rt=1 when entry[1] matches with memread=0.
- The WB stage relies on regfile write-before-read.

While Reset is low, all outputs are forced: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=1, all fwd selects 0, hazard_stall=0.

Latency:
- Stall and forward decisions are same-cycle combinational from registered scoreboard state plus ID inputs.
- A load-use stall lasts exactly 1 cycle; a branch-on-load stall lasts 2 cycles.
- ext_stall never creates bubbles.

Optional Feature:
Macro HAZ_PERF_EN.
- Defined:
  - Adds outputs stall_cnt, flush_cnt, fwd_cnt (CNT_W each), cleared by Reset.
  - stall_cnt increments on cycles with id_ex_bubble=1.
  - flush_cnt increments on cycles with if_id_flush=1.
  - fwd_cnt increments on cycles where any EX select is nonzero and ext_stall=0.
  - All counters saturate at all-ones rather than wrapping.
- Undefined: the ports and counters are absent; core behaviour is unchanged.

Test Plan:
lw $2,0($1) ; add $3,$2,$4 -> one cycle with hazard_stall=1, pc_en=0, id_ex_bubble=1; next cycle add in EX with ex_fwd_rs=2.
add $2,$1,$1 ; sub $5,$2,$2 -> no stall; sub in EX with ex_fwd_rs=1, ex_fwd_rt=1; add $2 ; add $2 ; or $6,$2 -> ex_fwd_rs=1 (youngest).
add $2,.. ; beq $2,$0 -> 1 stall cycle, then id_fwd_rs=1; lw $2 ; beq $2 -> 2 stall cycles, then id_fwd_rs=0.
Taken beq with no hazard -> if_id_flush=1 for one cycle; taken beq with hazard -> flush deferred until the stall clears.
ext_stall=1 for 3 cycles during a load-use pair -> scoreboard frozen, id_ex_bubble=0 throughout, stall resolves after release; add $0,.. ; use $0 -> no stall, selects 0.
Reset pulled low mid-stall (asynchronously) -> outputs immediately take reset values, scoreboard empty; after release the first instruction flows with no stall.
